// File: rtl/k2red_combine.sv
// k2red_combine: final arithmetic of one K2-RED round, R = k*AL - AH.
// k*AL is formed by a bit-serial shift-add multiplier (one bit of k per cycle),
// then AH is subtracted with sign extension, so R is exact at RW bits.
// One operation in flight; valid/ready handshake on input and output sides.
module k2red_combine #(
  parameter int W  = 64,
  parameter int KW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W-1:0]            AH,
  input  logic [W-1:0]            AL,
  input  logic [KW-1:0]           K,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [W+KW:0]    R,
  output logic                    busy
);

  // Signed result width; the accumulator is one bit narrower and unsigned.
  localparam int RW = W + KW + 1;
  localparam int AW = RW - 1;
  localparam int CW = (KW > 1) ? $clog2(KW) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_SUB  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Architectural state
  state_t                 r_state;
  logic [W-1:0]           r_ah;
  logic [W-1:0]           r_al;
  logic [KW-1:0]          r_k;
  logic [AW-1:0]          r_acc;
  logic [CW-1:0]          r_cnt;
  logic signed [RW-1:0]   r_r;
  logic                   r_out_valid;

  // Next-state values
  state_t                 w_state_nxt;
  logic [W-1:0]           w_ah_nxt;
  logic [W-1:0]           w_al_nxt;
  logic [KW-1:0]          w_k_nxt;
  logic [AW-1:0]          w_acc_nxt;
  logic [CW-1:0]          w_cnt_nxt;
  logic signed [RW-1:0]   w_r_nxt;
  logic                   w_out_valid_nxt;

  // Datapath helpers
  logic                   w_accept;
  logic                   w_last_bit;
  logic [AW-1:0]          w_al_ext;
  logic [AW-1:0]          w_al_shift;
  logic signed [RW-1:0]   w_acc_signed;
  logic signed [RW-1:0]   w_ah_signed;
  logic signed [RW-1:0]   w_diff;

  // Partial product: zero-extended AL shifted to the weight of the current k bit.
  // The acc width covers k*AL for any k < 2^KW and AL < 2^W, so no carry is lost.
  assign w_al_ext     = {{KW{1'b0}}, r_al};
  assign w_al_shift   = w_al_ext << r_cnt;
  assign w_last_bit   = (r_cnt == CW'(KW - 1));

  // Final subtraction at full signed width; AH is sign-extended, acc zero-extended,
  // which keeps AH = -2^(W-1) exact.
  assign w_acc_signed = $signed({1'b0, r_acc});
  assign w_ah_signed  = $signed({{(KW + 1){r_ah[W-1]}}, r_ah});
  assign w_diff       = w_acc_signed - w_ah_signed;

  // Accept only from IDLE; in_valid is ignored in every other state.
  assign w_accept     = in_valid && (r_state == S_IDLE);

  // FSM next-state and datapath next values; everything holds unless a state updates it.
  always_comb begin
    w_state_nxt     = r_state;
    w_ah_nxt        = r_ah;
    w_al_nxt        = r_al;
    w_k_nxt         = r_k;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_r_nxt         = r_r;
    w_out_valid_nxt = r_out_valid;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_ah_nxt    = AH;
          w_al_nxt    = AL;
          w_k_nxt     = K;
          w_acc_nxt   = {AW{1'b0}};
          w_cnt_nxt   = {CW{1'b0}};
          w_state_nxt = S_MUL;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MUL: begin
        // Fixed KW iterations: zero bits of k still cost a cycle.
        if (r_k[r_cnt]) begin
          w_acc_nxt = r_acc + w_al_shift;
        end else begin
          w_acc_nxt = r_acc;
        end
        w_cnt_nxt = r_cnt + CW'(1);
        if (w_last_bit) begin
          w_state_nxt = S_SUB;
        end else begin
          w_state_nxt = S_MUL;
        end
      end
      S_SUB: begin
        w_r_nxt         = w_diff;
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = S_DONE;
      end
      S_DONE: begin
        // R and out_valid stay put until the consumer takes the result.
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end else begin
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_DONE;
        end
      end
      default: begin
        w_out_valid_nxt = 1'b0;
        w_state_nxt     = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins in every state and drops any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ah        <= {W{1'b0}};
      r_al        <= {W{1'b0}};
      r_k         <= {KW{1'b0}};
      r_acc       <= {AW{1'b0}};
      r_cnt       <= {CW{1'b0}};
      r_r         <= {RW{1'b0}};
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ah        <= w_ah_nxt;
      r_al        <= w_al_nxt;
      r_k         <= w_k_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_r         <= w_r_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // Outputs come straight from registers; in_ready is additionally forced low in reset.
  assign R         = r_r;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != S_IDLE);
  assign in_ready  = (r_state == S_IDLE) && !rst;

endmodule

// File: tb/tb_k2red_combine.sv
// Self-checking bench for k2red_combine: directed corner cases plus random
// operations, each checked against a plain-arithmetic model of k*AL - AH.
module tb_k2red_combine;

  localparam int W  = 64;
  localparam int KW = 16;
  localparam int RW = W + KW + 1;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [W-1:0]          AH;
  logic [W-1:0]          AL;
  logic [KW-1:0]         K;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [RW-1:0]  R;
  logic                  busy;

  int errors = 0;
  int checks = 0;

  k2red_combine #(.W(W), .KW(KW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .AH        (AH),
    .AL        (AL),
    .K         (K),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact product in 128 bits minus sign-extended AH, truncated to RW bits.
  function automatic logic [RW-1:0] ref_r(input logic [KW-1:0] k,
                                          input logic [W-1:0] al,
                                          input logic [W-1:0] ah);
    logic [127:0] prod;
    logic [127:0] sah;
    logic [127:0] diff;
    prod = {{(128-KW){1'b0}}, k} * {{(128-W){1'b0}}, al};
    sah  = {{(128-W){ah[W-1]}}, ah};
    diff = prod - sah;
    return diff[RW-1:0];
  endfunction

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // One full operation: accept, latency count, result, optional output stall, release.
  task automatic do_op(input string tag, input logic [KW-1:0] k, input logic [W-1:0] al,
                       input logic [W-1:0] ah, input int hold);
    logic [RW-1:0] exp;
    logic [RW-1:0] held;
    int n;
    exp = ref_r(k, al, ah);
    @(negedge clk);
    in_valid  = 1'b1;
    K         = k;
    AL        = al;
    AH        = ah;
    out_ready = 1'b0;
    check({tag, "_in_ready_idle"}, RW'(in_ready), RW'(1));
    @(posedge clk);
    #1;
    // Inputs may change freely after the accepting edge.
    in_valid = 1'b0;
    K        = KW'($urandom());
    AL       = rnd64();
    AH       = rnd64();
    check({tag, "_busy_after_accept"}, RW'(busy), RW'(1));
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, RW'(n), RW'(KW + 1));
    check({tag, "_R"}, R, exp);
    held = R;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = $urandom_range(0, 1) == 1;
      AH       = rnd64();
      AL       = rnd64();
      K        = KW'($urandom());
      @(posedge clk);
      #1;
      check({tag, "_hold_R"}, R, held);
      check({tag, "_hold_valid"}, RW'(out_valid), RW'(1));
      check({tag, "_hold_in_ready"}, RW'(in_ready), RW'(0));
    end
    if (hold > 0) begin
      check({tag, "_hold_R_exact"}, R, exp);
    end else begin
      check({tag, "_busy_done"}, RW'(busy), RW'(1));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_valid_cleared"}, RW'(out_valid), RW'(0));
    check({tag, "_idle_busy"}, RW'(busy), RW'(0));
    check({tag, "_idle_in_ready"}, RW'(in_ready), RW'(1));
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [RW-1:0] exp;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    AH        = '0;
    AL        = '0;
    K         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", RW'(out_valid), RW'(0));
    check("rst_R", R, RW'(0));
    check("rst_busy", RW'(busy), RW'(0));
    check("rst_in_ready", RW'(in_ready), RW'(0));
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    do_op("t1", 16'd3, 64'd5, 64'd2, 0);
    check("t1_model", ref_r(16'd3, 64'd5, 64'd2), RW'(13));
    do_op("t2_negah", 16'd5, 64'd7, -64'sd4, 0);
    do_op("t3_k0", 16'd0, 64'd1234, 64'd77, 0);
    do_op("t3_al0", 16'd119, 64'd0, {64{1'b1}}, 0);
    do_op("t4_max", {16{1'b1}}, {64{1'b1}}, {1'b1, 63'd0}, 0);
    do_op("t5_hold", 16'd119, 64'h0000_0000_7FFF_FFFF, 64'hFFFF_FFFF_FFFF_FF00, 10);

    // Reset in the middle of MUL, at cnt=8.
    exp = ref_r(16'd119, 64'd1000, 64'd3);
    @(negedge clk);
    in_valid = 1'b1;
    K        = 16'd119;
    AL       = 64'd1000;
    AH       = 64'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_busy", RW'(busy), RW'(0));
    check("t6_rst_valid", RW'(out_valid), RW'(0));
    check("t6_rst_R", R, RW'(0));
    check("t6_rst_in_ready", RW'(in_ready), RW'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("t6_no_output", RW'(out_valid), RW'(0));
    check("t6_idle", RW'(busy), RW'(0));
    do_op("t6_fresh", 16'd119, 64'd1000, 64'd3, 0);
    check("t6_model", exp, RW'(118997));

    // Random operations against the model.
    for (int i = 0; i < 8; i++) begin
      do_op("rnd", KW'($urandom()), rnd64(), rnd64(), (i == 3) ? 3 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
